// File: rtl/time_manager.sv
// -----------------------------------------------------------------------------
// time_manager
//
// Purpose:
//   Central time arbiter for an emulation fabric. Each cycle it finds the
//   earliest pending event among N_CLOCKS clock generators and, while running,
//   advances the broadcast emulated time to that event until the emulation
//   end time is reached.
//
// Ports:
//   clk_sys      in   1            system clock, rising edge
//   rst          in   1            synchronous active-high reset
//   time_clocks  in   N_CLOCKS*TW  next-event time of clock i at [i*TW +: TW]
//   time_stop    in   TW           emulation end time
//   start        in   1            leave IDLE
//   stall_req    in   1            pause time advance
//   time_next    out  TW           registered current emulated time
//   min_idx      out  IW           registered index of clock that set time_next
//   running      out  1            state is RUN
//   done         out  1            state is DONE
//   step_count   out  32           saturating count of time advances
//   mono_err     out  1            sticky "time went backwards" flag
//
// Configuration:
//   TIME_MANAGER_MONO_CHECK_EN  when defined, a backwards step in RUN sets the
//   sticky mono_err flag (the advance still happens). When undefined, mono_err
//   is tied low and no comparator exists.
// -----------------------------------------------------------------------------

package time_settings;
  typedef logic [31:0] time_t;
endpackage

// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start; outputs hold
// S_RUN   | advancing time to the earliest clock event each cycle
// S_PAUSE | stalled by stall_req; resumes RUN without advancing
// S_DONE  | end time reached; holds until reset
module time_manager #(
  parameter  int N_CLOCKS = 4,
  localparam int TW       = $bits(time_settings::time_t),
  localparam int IW       = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic [N_CLOCKS*TW-1:0]     time_clocks,
  input  logic [TW-1:0]              time_stop,
  input  logic                       start,
  input  logic                       stall_req,
  output time_settings::time_t       time_next,
  output logic [IW-1:0]              min_idx,
  output logic                       running,
  output logic                       done,
  output logic [31:0]                step_count,
  output logic                       mono_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   step_count_q, step_count_d;

  logic [TW-1:0] m_val;
  logic [IW-1:0] m_idx;
  logic          advance;

  // Linear minimum search; strict '<' keeps the lowest index on ties.
  always_comb begin
    m_val = time_clocks[0 +: TW];
    m_idx = '0;
    for (int i = 1; i < N_CLOCKS; i++) begin
      if (time_clocks[i*TW +: TW] < m_val) begin
        m_val = time_clocks[i*TW +: TW];
        m_idx = IW'(i);
      end
    end
  end

  // A step is taken whenever RUN is not stalled, whether it lands on the
  // minimum or is clamped to time_stop.
  assign advance = (state_q == S_RUN) && !stall_req;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= S_IDLE;
      time_q       <= '0;
      idx_q        <= '0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      idx_q        <= idx_d;
      step_count_q <= step_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    idx_d        = idx_q;
    step_count_d = step_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (stall_req) begin
          state_d = S_PAUSE;
        end else if (m_val < time_stop) begin
          // Equal-to-current minimum is still a legal (zero-length) step.
          time_d = m_val;
          idx_d  = m_idx;
          if (step_count_q != 32'hFFFF_FFFF) step_count_d = step_count_q + 32'd1;
        end else begin
          time_d  = time_stop;
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (!stall_req) state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef TIME_MANAGER_MONO_CHECK_EN
  logic mono_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mono_q <= 1'b0;
    end else if (advance && (m_val < time_q)) begin
      mono_q <= 1'b1;
    end
  end

  assign mono_err = mono_q;
`else
  assign mono_err = 1'b0;
`endif

  assign time_next  = time_q;
  assign min_idx    = idx_q;
  assign step_count = step_count_q;
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule

// File: doc/time_manager.md
TIME_MANAGER -- requirements
Module: time_manager

Interface
REQ-001 SHALL have parameter N_CLOCKS, default 4, number of clock generators arbitrated (1..16).
REQ-002 SHALL define TW = $bits(time_settings::time_t), the emulated-time width; it is not a parameter.
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port time_clocks  input  N_CLOCKS*TW  packed next-event times; clock i occupies bits [i*TW +: TW].
REQ-006 SHALL have port time_stop  input  TW  emulation end time.
REQ-007 SHALL have port start  input  1  leave IDLE.
REQ-008 SHALL have port stall_req  input  1  pause time advance.
REQ-009 SHALL have port time_next  output  TW (time_t)  registered current emulated time, broadcast to all clock generators.
REQ-010 SHALL have port min_idx  output  $clog2(N_CLOCKS) (min 1)  registered index of the clock that set time_next.
REQ-011 SHALL have port running  output  1  high when state is RUN.
REQ-012 SHALL have port done  output  1  high when state is DONE.
REQ-013 SHALL have port step_count  output  32  count of time advances.
REQ-014 SHALL have port mono_err  output  1  sticky monotonicity error.

Function
REQ-015 SHALL compute m = unsigned minimum of all N_CLOCKS time_clocks combinationally; on ties, the index is the lowest-numbered clock.
REQ-016 SHALL implement states IDLE, RUN, PAUSE and DONE; state, time_next, min_idx and step_count are registered, with 1-cycle latency from inputs.
REQ-017 IDLE: outputs hold; start=1 -> RUN next cycle; stall_req ignored.
REQ-018 RUN with stall_req=1: -> PAUSE; time_next, min_idx and step_count hold.
REQ-019 RUN with stall_req=0 and m < time_stop: time_next<=m, min_idx<=argmin, step_count+=1, stay in RUN.
REQ-020 RUN with stall_req=0 and m >= time_stop: time_next<=time_stop, min_idx holds, step_count unchanged, -> DONE.
REQ-021 PAUSE: when stall_req=0, -> RUN with no advance in that cycle; when stall_req=1, stay in PAUSE.
REQ-022 DONE: all outputs hold; exit only via rst; start ignored.
REQ-023 When m == current time_next in RUN, SHALL still load the value and increment step_count (zero-length step is legal).
REQ-024 step_count SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-025 start together with stall_req in IDLE -> RUN; stall_req takes effect the following cycle.
REQ-026 running and done SHALL be decoded from the registered state (no combinational path from inputs).

Reset
REQ-027 rst=1 at a clock edge -> state IDLE, time_next=0, min_idx=0, step_count=0, mono_err=0, running=0, done=0.
REQ-028 rst SHALL dominate start, stall_req and all state transitions, including mid-RUN and in DONE.

Configuration
REQ-029 Macro TIME_MANAGER_MONO_CHECK_EN defined: in RUN with stall_req=0, m < current time_next sets mono_err=1; the bit stays set until rst, and the advance still occurs.
REQ-030 Macro TIME_MANAGER_MONO_CHECK_EN undefined: mono_err tied 0 and no comparator is synthesized; all other behaviour is identical.

Verification
REQ-031 N_CLOCKS=4, time_stop=1000, clocks {40,25,60,25}, start pulse -> cycle after start: time_next=25, min_idx=1, step_count=1, running=1.
REQ-032 RUN, clocks step to {40,50,60,75}, stall_req high 3 cycles -> time_next stays 25 during PAUSE; 1 cycle after stall_req falls it is still 25; next cycle time_next=40, min_idx=0.
REQ-033 RUN, clocks {1200,1100,1500,1050}, time_stop=1000 -> next cycle time_next=1000, done=1, running=0; start pulse then leaves all outputs unchanged.
REQ-034 Macro defined, time_next=500, clocks {300,600,700,800} -> time_next=300 and mono_err=1; mono_err still 1 after clocks return to {900,...}; rst clears it to 0.
REQ-035 rst asserted mid-RUN with time_next=640 and step_count=12 -> next cycle all outputs at reset values, state IDLE; start required to resume.
REQ-036 step_count forced to 32'hFFFFFFFE and two advances applied -> step_count=32'hFFFFFFFF, with no wrap.
